// File: rtl/wallace_pkg.sv
// Shared types and constants for the Wallace multiplier datapath.
package wallace_pkg;
  localparam int N         = 8;       // operand width of the NxN multiplier
  localparam int PROD_W    = 2 * N;   // product width
  localparam int SPLIT_DEF = 8;       // default low-segment width for the final CPA

  // Residual rows left by the column compressors. The compressor-tree top uses this too.
  typedef struct packed {
    logic [PROD_W-1:0] sum;
    logic [PROD_W-1:0] carry;
  } rows_t;
endpackage

// File: rtl/wallace_cpa_pipe_if.sv
// Handshake bus between compressor tree, final CPA and product consumer.
interface wallace_cpa_pipe_if #(parameter int W = wallace_pkg::PROD_W);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_sum;
  logic [W-1:0] in_carry;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_prod;
  logic         out_ovf;

  // CPA side: consumes rows, produces the product
  modport slave (
    input  in_valid, in_sum, in_carry, out_ready,
    output in_ready, out_valid, out_prod, out_ovf
  );

  // Surrounding side: supplies rows, sinks the product
  modport master (
    output in_valid, in_sum, in_carry, out_ready,
    input  in_ready, out_valid, out_prod, out_ovf
  );
endinterface

// File: rtl/wallace_cpa_pipe_cpa_seg.sv
// Combinational ripple-carry segment built from full-adder cells.

// Single-bit full adder cell
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module cpa_seg #(
  parameter int WS = 8
) (
  input  logic [WS-1:0] a,
  input  logic [WS-1:0] b,
  input  logic          cin,
  output logic [WS-1:0] s,
  output logic          cout
);
  logic [WS:0] w_c;

  assign w_c[0] = cin;

  // Carry ripples LSB to MSB through one fa per bit
  for (genvar i = 0; i < WS; i++) begin : g_bit
    fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (w_c[i]),
      .s  (s[i]),
      .co (w_c[i+1])
    );
  end

  assign cout = w_c[WS];
endmodule

// File: rtl/wallace_cpa_pipe.sv
// Final carry-propagate adder of the Wallace multiplier: two-stage split ripple
// add (low segment in s1, high segment plus carry in s2) with valid/ready on both sides.
module wallace_cpa_pipe
  import wallace_pkg::*;
#(
  parameter int W     = PROD_W,
  parameter int SPLIT = SPLIT_DEF   // 1..W-1
) (
  input  logic                  clk,
  input  logic                  rst,
  wallace_cpa_pipe_if.slave     bus,
  output logic                  busy
);
  localparam int WH = W - SPLIT;

  // handshake
  logic w_s1_adv, w_s2_adv, w_acc;

  // stage 1 state
  logic          r_s1_valid;
  logic [SPLIT-1:0] r_lo;
  logic          r_c;
  logic [WH-1:0] r_hi_a;
  logic [WH-1:0] r_hi_b;

  // stage 2 state
  logic          r_s2_valid;
  logic [W-1:0]  r_prod;
  logic          r_ovf;

  // segment adder outputs
  logic [SPLIT-1:0] w_lo;
  logic             w_lo_c;
  logic [WH-1:0]    w_hi;
  logic             w_hi_c;

  // Ready chain: a stage may load if it is empty or the stage after it moves.
  // in_ready therefore depends combinationally on out_ready through both stages.
  assign w_s2_adv     = !r_s2_valid | bus.out_ready;
  assign w_s1_adv     = !r_s1_valid | w_s2_adv;
  assign bus.in_ready = w_s1_adv;
  assign w_acc        = bus.in_valid & w_s1_adv;

  cpa_seg #(.WS(SPLIT)) u_lo (
    .a    (bus.in_sum[SPLIT-1:0]),
    .b    (bus.in_carry[SPLIT-1:0]),
    .cin  (1'b0),
    .s    (w_lo),
    .cout (w_lo_c)
  );

  cpa_seg #(.WS(WH)) u_hi (
    .a    (r_hi_a),
    .b    (r_hi_b),
    .cin  (r_c),
    .s    (w_hi),
    .cout (w_hi_c)
  );

  // Stage 1: low sum and its carry, high operand halves passed through
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_lo       <= '0;
      r_c        <= 1'b0;
      r_hi_a     <= '0;
      r_hi_b     <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_acc;
      r_lo       <= w_lo;
      r_c        <= w_lo_c;
      r_hi_a     <= bus.in_sum[W-1:SPLIT];
      r_hi_b     <= bus.in_carry[W-1:SPLIT];
    end
  end

  // Stage 2: high sum with incoming carry, assemble product and overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_prod     <= '0;
      r_ovf      <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      r_prod     <= {w_hi, r_lo};
      r_ovf      <= w_hi_c;
    end
  end

  assign bus.out_valid = r_s2_valid;
  assign bus.out_prod  = r_prod;
  assign bus.out_ovf   = r_ovf;
  assign busy          = r_s1_valid | r_s2_valid;
endmodule

// File: tb/tb_wallace_cpa_pipe.sv
// Scoreboard bench for wallace_cpa_pipe (W=16, SPLIT=8).
// Driver pushes expected {ovf,prod} on accept; a negedge monitor pops on each output transfer.
module tb_wallace_cpa_pipe;
  import wallace_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  wallace_cpa_pipe_if #(.W(16)) ifc ();

  wallace_cpa_pipe #(.W(16), .SPLIT(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (ifc.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_acc  = 0;
  int n_out  = 0;
  int cyc    = 0;
  logic [16:0] exp_q[$];
  int          out_cyc[$];
  logic        held_v = 1'b0;
  logic [16:0] held_val;
  logic        done6 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: transfer happens on the next posedge iff out_valid & out_ready here
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v)
        check("stall_hold", {15'd0, ifc.out_valid, ifc.out_ovf, ifc.out_prod}, {15'd0, 1'b1, held_val});
      held_v = 1'b0;
      if (ifc.out_valid && ifc.out_ready) begin
        n_out++;
        out_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          check("prod", {15'd0, ifc.out_ovf, ifc.out_prod}, {15'd0, exp_q.pop_front()});
        end
      end else if (ifc.out_valid) begin
        held_v   = 1'b1;
        held_val = {ifc.out_ovf, ifc.out_prod};
      end
    end
  end

  // Present one pair until accepted; returns just after the accepting edge
  task automatic send(input logic [15:0] s, input logic [15:0] c, input logic [16:0] e);
    int t = 0;
    ifc.in_valid = 1'b1;
    ifc.in_sum   = s;
    ifc.in_carry = c;
    forever begin
      @(negedge clk);
      if (ifc.in_ready) begin
        exp_q.push_back(e);
        n_acc++;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      t++;
      if (t > 200) begin
        check("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [15:0] s, c;
    s = 16'($urandom);
    c = 16'($urandom);
    send(s, c, {1'b0, s} + {1'b0, c});
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  // Output must appear exactly 2 cycles after the accept cycle
  task automatic check_latency2(input string name);
    @(negedge clk);
    check({name, "_not_yet"}, {31'd0, ifc.out_valid}, 32'd0);
    @(negedge clk);
    check({name, "_valid"}, {31'd0, ifc.out_valid}, 32'd1);
  endtask

  initial begin
    rows_t t4 [3];
    int    k, n0, dropped;

    ifc.in_valid  = 1'b0;
    ifc.in_sum    = '0;
    ifc.in_carry  = '0;
    ifc.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_prod", {15'd0, ifc.out_ovf, ifc.out_prod}, 32'd0);
    check("rst_in_ready", {31'd0, ifc.in_ready}, 32'd1);
    rst = 1'b0;
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;

    // 1: carry crosses the split
    send(16'h00FF, 16'h0001, 17'h00100);
    check_latency2("t1_latency");
    drain();

    // 2: wrap with overflow, then a plain sum
    send(16'hFFFF, 16'h0001, 17'h10000);
    send(16'h1234, 16'h4321, 17'h05555);
    drain();

    // 3: back-to-back stream, one result per cycle
    n0 = out_cyc.size();
    for (int i = 0; i < 8; i++) send_rand();
    drain();
    check("t3_count", out_cyc.size() - n0, 32'd8);
    if (out_cyc.size() >= n0 + 8)
      check("t3_consecutive", out_cyc[n0+7] - out_cyc[n0], 32'd7);

    // 4: output stalled; only two pairs fit, third enters when out_ready rises
    t4[0] = '{sum: 16'h1111, carry: 16'h2222};   // 3333
    t4[1] = '{sum: 16'h8000, carry: 16'h8000};   // 0000, ovf
    t4[2] = '{sum: 16'hABCD, carry: 16'h1111};   // BCDE
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    k = 0;
    for (int c5 = 0; c5 < 5; c5++) begin
      ifc.in_sum   = t4[k].sum;
      ifc.in_carry = t4[k].carry;
      @(negedge clk);
      if (ifc.in_ready) begin
        exp_q.push_back({1'b0, t4[k].sum} + {1'b0, t4[k].carry});
        n_acc++;
        k++;
      end
      @(posedge clk); #1;
    end
    check("t4_accepted", k, 32'd2);
    check("t4_in_ready_low", {31'd0, ifc.in_ready}, 32'd0);
    ifc.in_sum    = t4[2].sum;
    ifc.in_carry  = t4[2].carry;
    ifc.out_ready = 1'b1;
    @(negedge clk);
    check("t4_ready_on_release", {31'd0, ifc.in_ready}, 32'd1);
    if (ifc.in_ready) begin
      exp_q.push_back(17'h0BCDE);
      n_acc++;
    end
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    drain();

    // 5: reset with both stages full
    ifc.out_ready = 1'b0;
    send(16'h0F0F, 16'h0101, 17'h01010);
    send(16'h2000, 16'h0202, 17'h02202);
    check("t5_busy_full", {31'd0, busy}, 32'd1);
    check("t5_valid_full", {31'd0, ifc.out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_prod", {15'd0, ifc.out_ovf, ifc.out_prod}, 32'd0);
    dropped = exp_q.size();
    exp_q.delete();
    n_acc -= dropped;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ifc.out_ready = 1'b1;
    send(16'h7F80, 16'h0080, 17'h08000);
    check_latency2("t5_latency");
    drain();

    // 6: random traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send_rand();
        end
        done6 = 1'b1;
      end
      begin
        while (!done6) begin
          ifc.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    ifc.out_ready = 1'b1;
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_loss_dup", n_out, n_acc);
    check("t6_idle_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
